// File: rtl/clk_lock_monitor_if.sv
`default_nettype none
// ============================================================================
// Module      : clk_lock_monitor_if
// Description : Control/status bundle between the clock lock monitor and its
//               consumer (status/LED logic, start-up gating).
// Revision    : 1.0 - initial release
// ============================================================================
interface clk_lock_monitor_if #(
  parameter int CNT_W = 16
);
  logic             en;
  logic             sig_in;
  logic [CNT_W-1:0] freq_cnt;
  logic             cnt_valid;
  logic             in_range;
  logic             overflow;
  logic             locked;

  // Consumer side: enables measurement and supplies the clock under test
  modport master (
    output en,
    output sig_in,
    input  freq_cnt,
    input  cnt_valid,
    input  in_range,
    input  overflow,
    input  locked
  );

  // Monitor side
  modport slave (
    input  en,
    input  sig_in,
    output freq_cnt,
    output cnt_valid,
    output in_range,
    output overflow,
    output locked
  );
endinterface
`default_nettype wire

// File: rtl/clk_lock_monitor.sv
`default_nettype none
// ============================================================================
// Module      : clk_lock_monitor
// Description : Counts rising edges of an asynchronous PLL-derived tick over a
//               fixed gate window of system clocks, range-checks each window
//               and declares lock after enough consecutive good windows.
// Revision    : 1.0 - initial release
// ============================================================================
module clk_lock_monitor #(
  parameter int GATE_CYCLES  = 80,
  parameter int CNT_W        = 16,
  parameter int EXP_MIN      = 9,
  parameter int EXP_MAX      = 11,
  parameter int LOCK_WINDOWS = 3
) (
  input  logic              clk,
  input  logic              rst,
  clk_lock_monitor_if.slave bus
);

  localparam int TMR_W = (GATE_CYCLES > 2) ? $clog2(GATE_CYCLES) : 1;
  localparam int STK_W = $clog2(LOCK_WINDOWS + 1);

  localparam logic [TMR_W-1:0] C_TMR_LAST = TMR_W'(GATE_CYCLES - 1);
  localparam logic [CNT_W-1:0] C_CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] C_EXP_MIN  = CNT_W'(EXP_MIN);
  localparam logic [CNT_W-1:0] C_EXP_MAX  = CNT_W'(EXP_MAX);
  localparam logic [STK_W-1:0] C_LOCK_N   = STK_W'(LOCK_WINDOWS);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ACQUIRE = 2'd1,
    ST_LOCKED  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [2:0]       sync_q;              // [0],[1] synchronizer, [2] history
  logic [TMR_W-1:0] timer_q, timer_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             ovf_flag_q, ovf_flag_d;
  logic [STK_W-1:0] streak_q, streak_d;
  logic [CNT_W-1:0] freq_cnt_q, freq_cnt_d;
  logic             cnt_valid_q, cnt_valid_d;
  logic             in_range_q, in_range_d;
  logic             overflow_q, overflow_d;
  logic             locked_q, locked_d;

  logic             rise;
  logic [CNT_W-1:0] win_cnt;
  logic             win_ovf;
  logic             win_good;

  // Two-flop synchronizer plus history flop; runs in every state
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= 3'b000;
    end else begin
      sync_q <= {sync_q[1], sync_q[0], bus.sig_in};
    end
  end

  assign rise = sync_q[1] & ~sync_q[2];

  // State and measurement registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      timer_q     <= '0;
      count_q     <= '0;
      ovf_flag_q  <= 1'b0;
      streak_q    <= '0;
      freq_cnt_q  <= '0;
      cnt_valid_q <= 1'b0;
      in_range_q  <= 1'b0;
      overflow_q  <= 1'b0;
      locked_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      timer_q     <= timer_d;
      count_q     <= count_d;
      ovf_flag_q  <= ovf_flag_d;
      streak_q    <= streak_d;
      freq_cnt_q  <= freq_cnt_d;
      cnt_valid_q <= cnt_valid_d;
      in_range_q  <= in_range_d;
      overflow_q  <= overflow_d;
      locked_q    <= locked_d;
    end
  end

  // Next-state: gate timing, saturating count, window verdict and lock streak
  always_comb begin
    state_d     = state_q;
    timer_d     = timer_q;
    count_d     = count_q;
    ovf_flag_d  = ovf_flag_q;
    streak_d    = streak_q;
    freq_cnt_d  = freq_cnt_q;
    cnt_valid_d = 1'b0;
    in_range_d  = in_range_q;
    overflow_d  = overflow_q;
    locked_d    = locked_q;

    // Count including this cycle's edge, so the last cycle of a window counts
    win_cnt = count_q;
    win_ovf = ovf_flag_q;
    if (rise) begin
      if (count_q == C_CNT_MAX) begin
        win_ovf = 1'b1;
      end else begin
        win_cnt = count_q + 1'b1;
      end
    end
    win_good = !win_ovf && (win_cnt >= C_EXP_MIN) && (win_cnt <= C_EXP_MAX);

    case (state_q)
      ST_IDLE: begin
        timer_d    = '0;
        count_d    = '0;
        ovf_flag_d = 1'b0;
        streak_d   = '0;
        locked_d   = 1'b0;
        if (bus.en) begin
          state_d = ST_ACQUIRE;
        end
      end

      ST_ACQUIRE, ST_LOCKED: begin
        if (timer_q == C_TMR_LAST) begin
          // Window complete: publish and restart with no dead cycle
          freq_cnt_d  = win_cnt;
          cnt_valid_d = 1'b1;
          overflow_d  = win_ovf;
          in_range_d  = win_good;
          timer_d     = '0;
          count_d     = '0;
          ovf_flag_d  = 1'b0;
          if (win_good) begin
            streak_d = (streak_q == C_LOCK_N) ? streak_q : streak_q + 1'b1;
            if (streak_d == C_LOCK_N) begin
              state_d  = ST_LOCKED;
              locked_d = 1'b1;
            end
          end else begin
            streak_d = '0;
            state_d  = ST_ACQUIRE;
            locked_d = 1'b0;
          end
        end else begin
          timer_d    = timer_q + 1'b1;
          count_d    = win_cnt;
          ovf_flag_d = win_ovf;
        end

        // Disable aborts the partial window; a just-completed one still reports
        if (!bus.en) begin
          state_d    = ST_IDLE;
          timer_d    = '0;
          count_d    = '0;
          ovf_flag_d = 1'b0;
          streak_d   = '0;
          locked_d   = 1'b0;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign bus.freq_cnt  = freq_cnt_q;
  assign bus.cnt_valid = cnt_valid_q;
  assign bus.in_range  = in_range_q;
  assign bus.overflow  = overflow_q;
  assign bus.locked    = locked_q;

endmodule
`default_nettype wire

// File: tb/tb_clk_lock_monitor.sv
`default_nettype none
// ============================================================================
// Module      : tb_clk_lock_monitor
// Description : Scoreboard bench for clk_lock_monitor. Two instances share the
//               stimulus: the default build and a narrow-counter build that
//               saturates. A window-level reference model predicts reports.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_clk_lock_monitor;

  localparam int GATE  = 80;
  localparam int LOCKW = 3;

  typedef struct {
    int cyc;
    int cnt;
    bit good;
    bit ovf;
    bit lk;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic en  = 1'b0;
  logic sig = 1'b0;

  clk_lock_monitor_if #(.CNT_W(16)) b0 ();
  clk_lock_monitor_if #(.CNT_W(3))  b1 ();

  assign b0.en     = en;
  assign b0.sig_in = sig;
  assign b1.en     = en;
  assign b1.sig_in = sig;

  clk_lock_monitor #(
    .GATE_CYCLES(GATE), .CNT_W(16), .EXP_MIN(9), .EXP_MAX(11), .LOCK_WINDOWS(LOCKW)
  ) u_dut0 (
    .clk(clk), .rst(rst), .bus(b0.slave)
  );

  clk_lock_monitor #(
    .GATE_CYCLES(GATE), .CNT_W(3), .EXP_MIN(1), .EXP_MAX(5), .LOCK_WINDOWS(LOCKW)
  ) u_dut1 (
    .clk(clk), .rst(rst), .bus(b1.slave)
  );

  always #5 clk = ~clk;

  // ---------------------------------------------------------------- counters
  int n_cmp = 0;
  int n_err = 0;

  // ------------------------------------------------------------ model state
  // Cycle numbers label the interval following the cyc-th rising clk edge.
  int   cyc       = 0;
  bit   active    = 1'b0;
  int   win_start = 0;
  bit   prev_s    = 1'b0;
  int   dets[$];                       // intervals in which a rise is visible
  int   cmax[2]   = '{65535, 7};
  int   elo[2]    = '{9, 1};
  int   ehi[2]    = '{11, 5};
  int   good_run[2];
  bit   m_lk[2];
  int   m_fc[2];
  bit   m_ir[2];
  bit   m_ov[2];
  exp_t sb0[$];
  exp_t sb1[$];

  int   period = 8;

  // Signal under test: square wave of 'period' clk cycles (0 = stuck low)
  initial begin
    int ph;
    ph = 0;
    forever begin
      @(negedge clk);
      if (period == 0) begin
        sig = 1'b0;
      end else begin
        ph  = (ph + 1) % period;
        sig = (ph < period / 2);
      end
    end
  end

  // Reference model: windows are GATE intervals long beginning at the interval
  // the block activates; a rise of sig_in first sampled at edge r becomes
  // visible (and countable) in interval r+1. Lock = last LOCKW windows good.
  initial begin
    int   n;
    int   c;
    bit   o;
    bit   g;
    exp_t e;
    forever begin
      @(posedge clk);
      cyc++;
      if (rst) begin
        active = 1'b0;
        prev_s = 1'b0;
        dets.delete();
        for (int k = 0; k < 2; k++) begin
          good_run[k] = 0; m_lk[k] = 1'b0; m_fc[k] = 0; m_ir[k] = 1'b0; m_ov[k] = 1'b0;
        end
      end else begin
        if (sig && !prev_s) dets.push_back(cyc + 1);
        prev_s = sig;
        if (active && cyc == win_start + GATE) begin
          n = 0;
          foreach (dets[i]) if (dets[i] >= win_start && dets[i] < win_start + GATE) n++;
          for (int k = 0; k < 2; k++) begin
            o = (n > cmax[k]);
            c = o ? cmax[k] : n;
            g = !o && (c >= elo[k]) && (c <= ehi[k]);
            good_run[k] = g ? good_run[k] + 1 : 0;
            m_lk[k] = (good_run[k] >= LOCKW) && en;
            if (!en) good_run[k] = 0;
            m_fc[k] = c; m_ir[k] = g; m_ov[k] = o;
            e.cyc = cyc; e.cnt = c; e.good = g; e.ovf = o; e.lk = m_lk[k];
            if (k == 0) sb0.push_back(e); else sb1.push_back(e);
          end
          win_start = cyc;
          while (dets.size() > 0 && dets[0] < win_start) void'(dets.pop_front());
          if (!en) active = 1'b0;
        end else if (active && !en) begin
          active = 1'b0;
          for (int k = 0; k < 2; k++) begin
            good_run[k] = 0; m_lk[k] = 1'b0;
          end
        end else if (!active && en) begin
          active    = 1'b1;
          win_start = cyc;
        end
      end
    end
  end

  // Compare one instance: report pulses against the scoreboard, status always
  task automatic check_dut(input int k, input bit v, input int f, input bit r,
                           input bit o, input bit l);
    exp_t e;
    bit   have;
    have = (k == 0) ? (sb0.size() > 0) : (sb1.size() > 0);
    if (have) e = (k == 0) ? sb0[0] : sb1[0];
    if (v || (have && e.cyc <= cyc)) begin
      n_cmp++;
      if (!have || e.cyc != cyc || !v) begin
        n_err++;
        $display("FAIL report_timing dut%0d cyc %0d: cnt_valid=%0d, expected report cyc=%0d",
                 k, cyc, v, have ? e.cyc : -1);
      end else if (f != e.cnt || r != e.good || o != e.ovf || l != e.lk) begin
        n_err++;
        $display("FAIL report_value dut%0d cyc %0d: got cnt=%0d rng=%0d ovf=%0d lk=%0d, expected cnt=%0d rng=%0d ovf=%0d lk=%0d",
                 k, cyc, f, r, o, l, e.cnt, e.good, e.ovf, e.lk);
      end
      if (have && e.cyc <= cyc) begin
        if (k == 0) void'(sb0.pop_front()); else void'(sb1.pop_front());
      end
    end
    n_cmp++;
    if (f != m_fc[k] || r != m_ir[k] || o != m_ov[k] || l != m_lk[k]) begin
      n_err++;
      $display("FAIL status dut%0d cyc %0d: got cnt=%0d rng=%0d ovf=%0d lk=%0d, expected cnt=%0d rng=%0d ovf=%0d lk=%0d",
               k, cyc, f, r, o, l, m_fc[k], m_ir[k], m_ov[k], m_lk[k]);
    end
  endtask

  // Monitor: samples on the falling edge, away from register updates
  initial begin
    forever begin
      @(negedge clk);
      if (cyc >= 1) begin
        check_dut(0, b0.cnt_valid, int'(b0.freq_cnt), b0.in_range, b0.overflow, b0.locked);
        check_dut(1, b1.cnt_valid, int'(b1.freq_cnt), b1.in_range, b1.overflow, b1.locked);
      end
    end
  end

  task automatic run(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Stimulus
  initial begin
    int  pers[6] = '{0, 4, 7, 8, 9, 16};
    int  act;
    bit  hit;
    run(3);
    rst = 1'b0;
    run(2);

    // Nominal rate: lock after three good windows
    period = 8; en = 1'b1;
    run(5 * GATE);
    // Slow rate loses lock, nominal rate re-acquires
    period = 16;
    run(3 * GATE);
    period = 8;
    run(4 * GATE);
    // Fast rate: narrow counter saturates
    period = 4;
    run(3 * GATE);
    // Lock, then one-cycle enable drop mid-window
    period = 8;
    run(4 * GATE + $urandom_range(5, 60));
    en = 1'b0; run(1); en = 1'b1;
    run(4 * GATE);
    // One-cycle reset while locked and enabled
    rst = 1'b1; run(1); rst = 1'b0;
    run(4 * GATE);
    // Enable dropped exactly at a window-end edge
    hit = 1'b0;
    for (int i = 0; i < 3 * GATE && !hit; i++) begin
      if (active && cyc == win_start + GATE - 1) hit = 1'b1;
      else run(1);
    end
    n_cmp++;
    if (!hit) begin
      n_err++;
      $display("FAIL window_end_search: found=%0d, expected 1", hit);
    end
    en = 1'b0; run(3); en = 1'b1;
    run(2 * GATE);
    // Stuck input
    period = 0;
    run(3 * GATE + 4);

    // Randomised mix of rates, enable drops and resets
    for (int it = 0; it < 14; it++) begin
      period = ($urandom_range(0, 1) == 0) ? 8 : pers[$urandom_range(0, 5)];
      act = $urandom_range(0, 9);
      if (act == 0) begin
        rst = 1'b1; run(1); rst = 1'b0;
      end else if (act == 1) begin
        en = 1'b0; run($urandom_range(1, 5)); en = 1'b1;
      end
      run($urandom_range(60, 300));
    end

    en = 1'b0;
    run(4);
    n_cmp++;
    if (sb0.size() != 0 || sb1.size() != 0) begin
      n_err++;
      $display("FAIL pending_reports: left dut0=%0d dut1=%0d, expected 0 0", sb0.size(), sb1.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
